ram64_arbiter: RTL
==================

# ram64_arbiter

Two-requester round-robin controller for the 64-word × 16-bit RAM (`RAM64_16bit`). It sits between two independent masters (port A, port B) and the single RAM instance. It serialises their read and write commands, drives the RAM's `read`, `write`, `add`, `in` and `en` pins, and returns registered read data with a one-cycle acknowledge pulse.

## Interface
Parameters:
- `ADDR_W`, default 6: RAM address width (64 words).
- `DATA_W`, default 16: RAM word width.

Ports:
- `clk` input 1: single clock; RAM shares it.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_a` / `req_b` input 1: level request; held until the matching ack is sampled.
- `we_a` / `we_b` input 1: 1 = write, 0 = read; stable while req is high.
- `addr_a` / `addr_b` input ADDR_W: word address.
- `wdata_a` / `wdata_b` input DATA_W: write data.
- `ack_a` / `ack_b` output 1: one-cycle pulse; the command has completed.
- `rdata` output DATA_W: registered read data; valid during the ack of a read.
- `busy` output 1: high in every state except IDLE.
- `ram_en` output 1: drives RAM `en1`.
- `ram_read` / `ram_write` output 1: drive RAM `read` / `write`.
- `ram_add` output ADDR_W: drives RAM `add`.
- `ram_in` output DATA_W: drives RAM `in`.
- `ram_out` input DATA_W: RAM `out`.

## Operation
- FSM has three states: IDLE → ACCESS → ACK → IDLE.
- **IDLE:**
  - If any req is high, select the winner and latch its `we`/`addr`/`wdata` plus the owner id at the edge, then go to ACCESS.
  - If no req is high, stay in IDLE.
- **ACCESS:**
  - `ram_en`=1 and `ram_add`=latched address.
  - Write command: `ram_write`=1, `ram_read`=0, `ram_in`=latched data.
  - Read command: `ram_read`=1, `ram_write`=0.
  - At the edge, a write commits in the RAM; a read captures `ram_out` into `rdata`. Then go to ACK.
- **ACK:**
  - Owner's ack=1. `ram_en`, `ram_read` and `ram_write` are all 0.
  - The last-owner pointer updates at the edge. Then go to IDLE.
- **Arbitration:**
  - If only one req is high, that port wins.
  - If both are high, the port that was not last served wins.
  - Last-owner resets to B, so A wins the first tie.
- **RAM drive outside ACCESS:** `ram_en`, `ram_read` and `ram_write` = 0; `ram_add` and `ram_in` hold the latched values (don't-care).
- **rdata:** holds the last read result until the next read completes. A write does not change it.
- **Requester rule:** a requester must drop or change req at the same edge where it samples its ack high. Because of this, a lingering req in the following IDLE cycle is treated as a new command.
- **Input changes:** changes to non-owner inputs during ACCESS/ACK are ignored; the command is latched.

## Timing
- **Reset values** (while `rst_n`=0, applied immediately):
  - state = IDLE
  - `ack_a` = `ack_b` = 0, `busy` = 0
  - `ram_en` = `ram_read` = `ram_write` = 0
  - `ram_add` = 0, `ram_in` = 0, `rdata` = 0
  - last-owner = B
- **Latency:** req high before edge k → ACCESS in cycle k..k+1 → ack high in cycle k+1..k+2. Read data is on `rdata` with the ack.
- **Throughput:** one command per 3 cycles. Back-to-back requests from both ports alternate A, B, A, B.
- **Simultaneous events:** a new req arriving during ACCESS/ACK waits. A req that arrives in ACK from the non-owner wins at the next IDLE edge.
- **Reset mid-operation:**
  - Reset asserted in ACCESS drops `ram_write` asynchronously, so the write is aborted and no ack is issued.
  - The requester must reissue after reset.

## Structure
- Shared definitions file `ram_ctrl_defs.vh` holds:
  - State encodings `ST_IDLE`=2'd0, `ST_ACCESS`=2'd1, `ST_ACK`=2'd2.
  - Owner encodings `OWN_A`=0, `OWN_B`=1.
  - `RAM_ADDR_W`=6 and `RAM_DATA_W`=16.
- Sub-module `rr_arb2`: combinational two-way round-robin pick (`req_a`, `req_b`, `last_owner` → `grant_valid`, `grant_owner`).
- Top level contains the FSM, command latch and rdata register.
- The integration testbench instantiates `RAM64_16bit` as the real target.

## Test plan
- **Single write then read:** reset, A writes 16'hBEEF to addr 6'd37, then A reads addr 37 → `ack_a` at cycle 2 of each op; `rdata`=16'hBEEF with the second ack; `ack_b` stays 0.
- **Simultaneous requests:** A and B both request in the same cycle (A reads addr 0, B writes 16'h1234 to addr 63) → A acked first, B acked 3 cycles later; RAM[63]=16'h1234 afterwards.
- **Round-robin fairness:** A and B hold req continuously for 6 commands → ack sequence A, B, A, B, A, B, with ack spacing of exactly 3 cycles.
- **rdata hold:** A reads 16'h00FF from addr 5, then B writes addr 5 → `rdata` stays 16'h00FF through B's ack.
- **Reset in ACCESS:** A writes 16'hAAAA to addr 12 and `rst_n` is pulsed low during ACCESS → `ram_write` drops immediately, no ack; after reset, reading addr 12 does not return 16'hAAAA (previously 0), and all outputs are 0 during reset.
- **Address extremes:** writes to addr 0 and addr 63 with distinct data, then read both back → exact data returned; neither write aliases onto the other address.

Source files
------------

// File: rtl/ram64_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram64_arbiter_pkg
// Shared definitions for the two-port RAM64 arbiter: FSM state encoding,
// owner encoding and the default RAM geometry.
// ----------------------------------------------------------------------------
package ram64_arbiter_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage : ram64_arbiter_pkg

// File: rtl/ram64_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
//   req_a, req_b   : pending requests
//   last_owner     : port served most recently
//   grant_valid    : at least one request is pending
//   grant_owner    : winning port (only meaningful when grant_valid)
// ----------------------------------------------------------------------------
module rr_arb2
    import ram64_arbiter_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = req_a | req_b;
        grant_owner = OWN_A;
        if (req_a && req_b) begin
            // Tie: the port that was not served last goes next.
            grant_owner = (last_owner == OWN_A) ? OWN_B : OWN_A;
        end else if (req_b) begin
            grant_owner = OWN_B;
        end
    end

endmodule : rr_arb2

// File: rtl/ram64_arbiter.sv
// ----------------------------------------------------------------------------
// ram64_arbiter
// Two-requester round-robin controller in front of a single 64x16 RAM.
// Each command takes IDLE -> ACCESS -> ACK (three cycles).
//   clk, rst_n                    : clock, async active-low reset
//   req_x/we_x/addr_x/wdata_x     : per-port command (x = a, b)
//   ack_a, ack_b                  : one-cycle completion pulse
//   rdata                         : registered read data, valid with the ack
//   busy                          : high whenever not IDLE
//   ram_en/ram_read/ram_write     : RAM strobes, only asserted in ACCESS
//   ram_add/ram_in                : latched address / write data to the RAM
//   ram_out                       : RAM read data
// ----------------------------------------------------------------------------
module ram64_arbiter
    import ram64_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    state_t              r_state;
    state_t              w_next_state;
    owner_t              r_owner;
    owner_t              r_last_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_grant_valid;
    owner_t              w_grant_owner;

    rr_arb2 u_arb (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_owner  (r_last_owner),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command latch: captured only on the IDLE edge that accepts a request,
    // so later changes on either port cannot disturb a command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_A;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == ST_IDLE && w_grant_valid) begin
            r_owner <= w_grant_owner;
            if (w_grant_owner == OWN_B) begin
                r_we    <= we_b;
                r_addr  <= addr_b;
                r_wdata <= wdata_b;
            end else begin
                r_we    <= we_a;
                r_addr  <= addr_a;
                r_wdata <= wdata_a;
            end
        end
    end

    // Read data register: only a completed read updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_state == ST_ACCESS && !r_we) begin
            r_rdata <= ram_out;
        end
    end

    // Fairness pointer advances only when a command is acknowledged, so an
    // aborted command (reset during ACCESS) never counts as served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= OWN_B;
        end else if (r_state == ST_ACK) begin
            r_last_owner <= r_owner;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next_state = r_state;
        ack_a        = 1'b0;
        ack_b        = 1'b0;
        busy         = 1'b1;
        ram_en       = 1'b0;
        ram_read     = 1'b0;
        ram_write    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_grant_valid) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_en       = 1'b1;
                ram_write    = r_we;
                ram_read     = ~r_we;
                w_next_state = ST_ACK;
            end
            ST_ACK: begin
                ack_a        = (r_owner == OWN_A);
                ack_b        = (r_owner == OWN_B);
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign ram_add = r_addr;
    assign ram_in  = r_wdata;
    assign rdata   = r_rdata;

endmodule : ram64_arbiter
